// File: rtl/serial_transmitter.sv
`default_nettype none
// serial_transmitter: 8N1 line driver (start 0, 8 data bits LSB-first, stop 1)
// with the bit period set by an internal divider of CLKS_PER_BIT clk cycles.
module serial_transmitter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_en,
   output logic       dout,
   output logic       tx_status
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state_q,  state_d;
   logic [BAUD_W-1:0] baud_q,   baud_d;
   logic [2:0]        bit_q,    bit_d;
   logic [7:0]        shift_q,  shift_d;
   logic              dout_q,   dout_d;
   logic              status_q, status_d;
   logic              bit_done;

   assign bit_done  = (baud_q == BAUD_LAST);
   assign dout      = dout_q;
   assign tx_status = status_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         dout_q   <= 1'b1;
         status_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         dout_q   <= dout_d;
         status_q <= status_d;
      end
   end

   // Outputs are computed one cycle ahead so dout/tx_status come straight from flops.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      status_d = status_q;

      case (state_q)
         S_IDLE: begin
            dout_d   = 1'b1;
            status_d = 1'b1;
            if (tx_en) begin
               shift_d  = tx_data;
               baud_d   = '0;
               bit_d    = '0;
               dout_d   = 1'b0;
               status_d = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               baud_d  = '0;
               dout_d  = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  dout_d  = 1'b1;
                  state_d = S_STOP;
               end else begin
                  dout_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               baud_d   = '0;
               dout_d   = 1'b1;
               status_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            dout_d   = 1'b1;
            status_d = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire
